seq_shift_unit: RTL and testbench

- Multi-cycle shifter for the processor datapath; shifts one bit position per clock.
- Performs the right shifts (SRL, SRA) and rotate right (ROR). Also performs SLL, so all register-amount shifts go through one unit.
- Sits beside the ALU. Control starts an operation with a start/done handshake and stalls while busy is high.

---
 rtl/seq_shift_unit.sv | 166 ++++++++++++++++
 tb/tb_seq_shift_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/seq_shift_unit.sv
// -----------------------------------------------------------------------------
// seq_shift_unit
// Multi-cycle shifter that moves the operand one bit position per clock.
// Supports SLL, SRL, SRA and ROR, so every register-amount shift in the
// datapath can share this one unit. Control starts an operation with
// start and waits for the one-cycle done pulse. It stalls while busy is high.
//
// Ports
//   clk    in   1        system clock, rising-edge active
//   rst_n  in   1        asynchronous active-low reset
//   start  in   1        request; accepted only in IDLE or DONE
//   op     in   2        00 SLL, 01 SRL, 10 SRA, 11 ROR
//   In32   in   WIDTH    operand, captured on acceptance
//   shamt  in   SHAMT_W  shift amount, captured on acceptance
//   busy   out  1        high while shifting (registered)
//   done   out  1        one-cycle pulse; Out32 valid from this cycle on
//   Out32  out  WIDTH    result register
// -----------------------------------------------------------------------------
module seq_shift_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   In32,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   Out32
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [SHAMT_W-1:0] C_ZERO = {SHAMT_W{1'b0}};
  localparam logic [SHAMT_W-1:0] C_ONE  = {{(SHAMT_W-1){1'b0}}, 1'b1};

  state_t             r_state;
  state_t             w_state_nxt;
  logic [SHAMT_W-1:0] r_count;
  logic [1:0]         r_op;
  logic [WIDTH-1:0]   r_out;
  logic               r_busy;
  logic               r_done;
  logic               w_busy_nxt;
  logic               w_done_nxt;
  logic               w_accept;

  // One-bit step of the selected shift/rotate.
  function automatic logic [WIDTH-1:0] shift_step(
    input logic [1:0]       op_sel,
    input logic [WIDTH-1:0] val
  );
    logic [WIDTH-1:0] res;
    case (op_sel)
      2'b00:   res = {val[WIDTH-2:0], 1'b0};
      2'b01:   res = {1'b0, val[WIDTH-1:1]};
      2'b10:   res = {val[WIDTH-1], val[WIDTH-1:1]};
      2'b11:   res = {val[0], val[WIDTH-1:1]};
      default: res = val;
    endcase
    return res;
  endfunction

  // A new request may start only when no shift is in flight.
  assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          // A zero amount needs no shift cycles and goes straight to DONE.
          if (shamt == C_ZERO) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_SHIFT;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (r_count == C_ONE) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_SHIFT;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state, so the registered busy/done line up with the state.
  always_comb begin
    w_busy_nxt = 1'b0;
    w_done_nxt = 1'b0;
    case (w_state_nxt)
      ST_SHIFT: begin
        w_busy_nxt = 1'b1;
        w_done_nxt = 1'b0;
      end
      ST_DONE: begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b1;
      end
      default: begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
      end
    endcase
  end

  // Registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
    end
  end

  // Operand capture and per-cycle shift datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out   <= {WIDTH{1'b0}};
      r_count <= C_ZERO;
      r_op    <= 2'b00;
    end else if (w_accept) begin
      r_out   <= In32;
      r_count <= shamt;
      r_op    <= op;
    end else if (r_state == ST_SHIFT) begin
      r_out   <= shift_step(r_op, r_out);
      r_count <= r_count - C_ONE;
    end else begin
      r_out   <= r_out;
      r_count <= r_count;
      r_op    <= r_op;
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign Out32 = r_out;

endmodule

// File: tb/tb_seq_shift_unit.sv
// -----------------------------------------------------------------------------
// tb_seq_shift_unit
// Self-checking bench for seq_shift_unit: directed vector table, hand-written
// multi-cycle corner sequences and random operations against a reference model.
// -----------------------------------------------------------------------------
module tb_seq_shift_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] In32;
  logic [4:0]  shamt;
  logic        busy;
  logic        done;
  logic [31:0] Out32;

  int cmp_cnt = 0;
  int err_cnt = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] in;
    logic [4:0]  sh;
    logic [31:0] exp;
    string       nm;
  } vec_t;

  vec_t tbl[6];

  seq_shift_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .In32  (In32),
    .shamt (shamt),
    .busy  (busy),
    .done  (done),
    .Out32 (Out32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: whole-amount shift computed directly from the operation's meaning.
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, input int s);
    logic [31:0] r;
    case (o)
      2'b00:   r = x << s;
      2'b01:   r = x >> s;
      2'b10:   r = $signed(x) >>> s;
      default: r = (s == 0) ? x : ((x >> s) | (x << (32 - s)));
    endcase
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  // Present a request so that the next rising edge samples it.
  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [4:0] s);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    In32  = x;
    shamt = s;
  endtask

  // Follow one operation from its accepting edge through done.
  // poke_k > 0 drives an extra start during shift cycle poke_k (must be ignored).
  // chain = 1 requests the next operation during the done cycle.
  task automatic track(input logic [4:0] sh, input logic [31:0] exp, input string nm,
                       input int poke_k, input bit chain,
                       input logic [1:0] c_op, input logic [31:0] c_in, input logic [4:0] c_sh);
    int bad;
    int n;
    bad = 0;
    n   = int'(sh);
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 2'($urandom_range(0, 3));
    In32  = $urandom;
    shamt = 5'($urandom_range(0, 31));
    for (int k = 1; k <= n + 1; k++) begin
      @(negedge clk);
      if (k <= n) begin
        if (!(busy === 1'b1 && done === 1'b0)) bad++;
      end else begin
        if (!(busy === 1'b0 && done === 1'b1)) bad++;
      end
      if (poke_k > 0 && k == poke_k) begin
        start = 1'b1;
        op    = 2'b00;
        In32  = 32'h0000_0000;
        shamt = 5'd3;
      end else if (poke_k > 0 && k == poke_k + 1) begin
        start = 1'b0;
      end
    end
    check({nm, " handshake_errors"}, 32'(bad), 32'd0);
    check({nm, " result"}, Out32, exp);
    if (chain) begin
      start = 1'b1;
      op    = c_op;
      In32  = c_in;
      shamt = c_sh;
    end else begin
      @(negedge clk);
      check({nm, " done_one_cycle"}, {30'd0, busy, done}, 32'd0);
      check({nm, " hold"}, Out32, exp);
    end
  endtask

  initial begin
    logic [1:0]  r_o;
    logic [31:0] r_x;
    logic [4:0]  r_s;
    int          late_done;

    tbl[0] = '{op: 2'b00, in: 32'h0000_0001, sh: 5'd4,  exp: 32'h0000_0010, nm: "sll_1_4"};
    tbl[1] = '{op: 2'b01, in: 32'h8000_0000, sh: 5'd31, exp: 32'h0000_0001, nm: "srl_msb_31"};
    tbl[2] = '{op: 2'b10, in: 32'h8000_00F0, sh: 5'd4,  exp: 32'hF800_000F, nm: "sra_neg_4"};
    tbl[3] = '{op: 2'b10, in: 32'h7000_0000, sh: 5'd4,  exp: 32'h0700_0000, nm: "sra_pos_4"};
    tbl[4] = '{op: 2'b11, in: 32'h0000_0001, sh: 5'd1,  exp: 32'h8000_0000, nm: "ror_1_1"};
    tbl[5] = '{op: 2'b11, in: 32'h1234_5678, sh: 5'd0,  exp: 32'h1234_5678, nm: "ror_sh0"};

    rst_n = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    In32  = 32'h0000_0000;
    shamt = 5'd0;
    repeat (3) @(negedge clk);
    check("reset_out", Out32, 32'h0000_0000);
    check("reset_flags", {30'd0, busy, done}, 32'd0);
    rst_n = 1'b1;

    // Directed vectors.
    for (int i = 0; i < 6; i++) begin
      launch(tbl[i].op, tbl[i].in, tbl[i].sh);
      track(tbl[i].sh, tbl[i].exp, tbl[i].nm, 0, 1'b0, 2'b00, 32'h0, 5'd0);
    end

    // start during SHIFT is ignored.
    launch(2'b01, 32'hFFFF_FFFF, 5'd8);
    track(5'd8, 32'h00FF_FFFF, "srl_poke_ignored", 3, 1'b0, 2'b00, 32'h0, 5'd0);

    // Back-to-back request in the done cycle.
    launch(2'b10, 32'h8000_0000, 5'd2);
    track(5'd2, 32'hE000_0000, "b2b_first", 0, 1'b1, 2'b00, 32'h0000_0001, 5'd1);
    track(5'd1, 32'h0000_0002, "b2b_second", 0, 1'b0, 2'b00, 32'h0, 5'd0);

    // Asynchronous reset in the middle of a shift.
    launch(2'b00, 32'hDEAD_BEEF, 5'd20);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midreset_out", Out32, 32'h0000_0000);
    check("midreset_flags", {30'd0, busy, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    late_done = 0;
    repeat (30) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) late_done++;
    end
    check("midreset_no_done", 32'(late_done), 32'd0);
    launch(2'b00, 32'h0000_0003, 5'd2);
    track(5'd2, 32'h0000_000C, "after_reset_sll", 0, 1'b0, 2'b00, 32'h0, 5'd0);

    // Random operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      r_o = 2'($urandom_range(0, 3));
      r_x = $urandom;
      r_s = 5'($urandom_range(0, 31));
      launch(r_o, r_x, r_s);
      track(r_s, model(r_o, r_x, int'(r_s)), $sformatf("rand%0d", i), 0, 1'b0, 2'b00, 32'h0, 5'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
